// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the multiply/divide unit.
//
// Contents:
//   OP_*     operation codes presented on muldiv_if.op
//   state_t  controller states (ST_IDLE, ST_RUN, ST_FIX)
//   FUNCT_*  SPECIAL-opcode funct fields of the HI/LO instructions, for the
//            instruction decoder
//   op_legal / op_is_div / op_is_signed  small op decode helpers
//
// Optional feature macro: MULDIV_MADD_EN. When defined, OP_MADDU and OP_MADD
// are accepted by op_legal; otherwise they decode as illegal.
package muldiv_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_MULTU = 3'b000;
    localparam logic [OP_W-1:0] OP_MULT  = 3'b001;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'b010;
    localparam logic [OP_W-1:0] OP_DIV   = 3'b011;
    localparam logic [OP_W-1:0] OP_MADDU = 3'b100;
    localparam logic [OP_W-1:0] OP_MADD  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        logic legal;
        legal = (op == OP_MULTU) || (op == OP_MULT) ||
                (op == OP_DIVU)  || (op == OP_DIV);
`ifdef MULDIV_MADD_EN
        legal = legal || (op == OP_MADDU) || (op == OP_MADD);
`endif
        return legal;
    endfunction

    function automatic logic op_is_div(input logic [OP_W-1:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if -- request/result bundle between the core and muldiv_unit.
//
// Signals:
//   start, op, a, b        operation request (sampled only while idle)
//   hi_we, lo_we, wdata    direct HI/LO writes (MTHI/MTLO)
//   busy                   operation in flight, controller stalls on it
//   done, dbz              one-cycle completion pulse and divide-by-zero flag
//   hi, lo                 architectural HI/LO registers (MFHI/MFLO)
//
// Modports: master = core side, slave = muldiv_unit side.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic              start;
    logic [OP_W-1:0]   op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              hi_we;
    logic              lo_we;
    logic [WIDTH-1:0]  wdata;
    logic              busy;
    logic              done;
    logic              dbz;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, dbz, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step -- one combinational iteration of the iterative datapath.
//
// Ports:
//   is_div      1 = restoring-divide step, 0 = shift-add multiply step
//   upper       multiply: running partial product high half
//               divide:   partial remainder
//   lower       multiply: multiplier being shifted out (low product bits in)
//               divide:   dividend being shifted out (quotient bits in)
//   operand     multiplicand (multiply) or divisor (divide), magnitudes
//   upper_next, lower_next  register values after this iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] upper,
    input  logic [WIDTH-1:0] lower,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] upper_next,
    output logic [WIDTH-1:0] lower_next
);
    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;

    always_comb begin
        // Multiply: conditionally add the multiplicand, then shift the
        // whole {carry, upper, lower} right by one.
        add_sum   = {1'b0, upper} + {1'b0, (lower[0] ? operand : '0)};
        // Divide: bring the next dividend bit into the remainder. The
        // remainder is always below the divisor, so the shifted value fits in
        // WIDTH+1 bits and diff's MSB is a clean borrow flag.
        rem_shift = {upper, lower[WIDTH-1]};
        diff      = rem_shift - {1'b0, operand};

        if (is_div) begin
            if (!diff[WIDTH]) begin
                upper_next = diff[WIDTH-1:0];
                lower_next = {lower[WIDTH-2:0], 1'b1};
            end else begin
                upper_next = rem_shift[WIDTH-1:0];
                lower_next = {lower[WIDTH-2:0], 1'b0};
            end
        end else begin
            upper_next = add_sum[WIDTH:1];
            lower_next = {add_sum[0], lower[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative multiply/divide unit holding architectural HI/LO.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  synchronous, active-high; aborts any operation in flight
//   bus    muldiv_if.slave (start/op/a/b, hi_we/lo_we/wdata, busy/done/dbz,
//          hi/lo)
//
// Operation: IDLE accepts a legal start and latches operand magnitudes; RUN
// performs WIDTH iterations (one per cycle) of shift-add multiply or
// restoring divide; FIX applies sign correction and writes HI/LO, pulsing
// done in the following cycle. Latency from the start edge to HI/LO update
// is WIDTH+1 edges.
//
// Optional feature macro: MULDIV_MADD_EN adds MADDU/MADD, which accumulate
// the product into {HI,LO} at FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam int            CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [CW-1:0]    step_cnt_reg;
    logic [WIDTH-1:0] upper_reg;
    logic [WIDTH-1:0] lower_reg;
    logic [WIDTH-1:0] operand_reg;
    logic [WIDTH-1:0] a_orig_reg;
    logic             is_div_reg;
    logic             neg_lo_reg;   // negate product / quotient at FIX
    logic             neg_hi_reg;   // negate remainder at FIX
    logic             b_zero_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             dbz_reg;
`ifdef MULDIV_MADD_EN
    logic             madd_reg;
`endif

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic             start_ok;
    logic             start_signed;
    logic             start_div;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        start_ok     = bus.start && op_legal(bus.op);
        start_signed = op_is_signed(bus.op);
        start_div    = op_is_div(bus.op);
        // The most-negative value maps onto itself, which is its correct
        // unsigned magnitude, so DIV overflow needs no special case.
        a_mag = (start_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (start_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] step_upper;
    logic [WIDTH-1:0] step_lower;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div     (is_div_reg),
        .upper      (upper_reg),
        .lower      (lower_reg),
        .operand    (operand_reg),
        .upper_next (step_upper),
        .lower_next (step_lower)
    );

    // ------------------------------------------------------------------
    // FIX-stage result formation
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_res;
    logic [2*WIDTH-1:0] acc_res;
    logic [WIDTH-1:0]   quot_res;
    logic [WIDTH-1:0]   rem_res;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        prod_mag = {upper_reg, lower_reg};
        prod_res = neg_lo_reg ? -prod_mag : prod_mag;
        quot_res = neg_lo_reg ? -lower_reg : lower_reg;
        rem_res  = neg_hi_reg ? -upper_reg : upper_reg;
`ifdef MULDIV_MADD_EN
        // Accumulate into the HI/LO value held at FIX; wraps at 2*WIDTH bits.
        acc_res  = madd_reg ? ({hi_reg, lo_reg} + prod_res) : prod_res;
`else
        acc_res  = prod_res;
`endif
        if (is_div_reg) begin
            if (b_zero_reg) begin
                // Divide by zero: quotient saturates, remainder is the
                // original dividend bit pattern.
                fix_hi = a_orig_reg;
                fix_lo = '1;
            end else begin
                fix_hi = rem_res;
                fix_lo = quot_res;
            end
        end else begin
            fix_hi = acc_res[2*WIDTH-1:WIDTH];
            fix_lo = acc_res[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Controller and architectural state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            step_cnt_reg <= '0;
            upper_reg    <= '0;
            lower_reg    <= '0;
            operand_reg  <= '0;
            a_orig_reg   <= '0;
            is_div_reg   <= 1'b0;
            neg_lo_reg   <= 1'b0;
            neg_hi_reg   <= 1'b0;
            b_zero_reg   <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            dbz_reg      <= 1'b0;
`ifdef MULDIV_MADD_EN
            madd_reg     <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        // Direct writes in this cycle are dropped.
                        state_reg    <= ST_RUN;
                        busy_reg     <= 1'b1;
                        step_cnt_reg <= '0;
                        upper_reg    <= '0;
                        is_div_reg   <= start_div;
                        a_orig_reg   <= bus.a;
                        b_zero_reg   <= (bus.b == '0);
                        neg_lo_reg   <= start_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_hi_reg   <= start_signed && bus.a[WIDTH-1];
`ifdef MULDIV_MADD_EN
                        madd_reg     <= (bus.op == OP_MADDU) || (bus.op == OP_MADD);
`endif
                        if (start_div) begin
                            lower_reg   <= a_mag;   // dividend
                            operand_reg <= b_mag;   // divisor
                        end else begin
                            lower_reg   <= b_mag;   // multiplier
                            operand_reg <= a_mag;   // multiplicand
                        end
                    end else begin
                        if (bus.hi_we) hi_reg <= bus.wdata;
                        if (bus.lo_we) lo_reg <= bus.wdata;
                    end
                end
                ST_RUN: begin
                    upper_reg    <= step_upper;
                    lower_reg    <= step_lower;
                    step_cnt_reg <= step_cnt_reg + 1'b1;
                    if (step_cnt_reg == LAST_STEP) begin
                        state_reg <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_reg    <= fix_hi;
                    lo_reg    <= fix_lo;
                    done_reg  <= 1'b1;
                    dbz_reg   <= is_div_reg && b_zero_reg;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.dbz  = dbz_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- scoreboard bench for muldiv_unit (WIDTH = 32).
// Stimulus pushes the expected HI/LO/dbz for every accepted operation; a
// monitor pops and compares on each done pulse. Expected values come from
// plain 64-bit arithmetic on the architectural HI/LO model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    logic clk;
    logic reset;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int           checks = 0;
    int           errors = 0;
    exp_t         exp_q[$];
    logic [W-1:0] model_hi;
    logic [W-1:0] model_lo;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz);
        exp_t e;
        e.hi  = hi;
        e.lo  = lo;
        e.dbz = dbz;
        return e;
    endfunction

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom());
        endcase
    endfunction

    // Monitor: one line per completed transaction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual hi=%h lo=%h required no done", bus.hi, bus.lo);
                end else begin
                    e = exp_q.pop_front();
                    $display("done hi=%h lo=%h dbz=%b (req hi=%h lo=%h dbz=%b)",
                             bus.hi, bus.lo, bus.dbz, e.hi, e.lo, e.dbz);
                    chk("result_hi", bus.hi, e.hi);
                    chk("result_lo", bus.lo, e.lo);
                    chk("result_dbz", bus.dbz, e.dbz);
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Issue one operation (called at a negedge, returns at the done negedge).
    // mode 0: plain; 1: start + HI/LO writes while busy; 2: writes with start.
    task automatic run_core(input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input exp_t e, input int mode);
        logic [W-1:0] prev_hi;
        logic [W-1:0] prev_lo;
        int           lat;
        int           busy_n;
        bit           seen;
        prev_hi = model_hi;
        prev_lo = model_lo;
        exp_q.push_back(e);
        model_hi = e.hi;
        model_lo = e.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (mode == 2) begin
            bus.hi_we = 1'b1;
            bus.lo_we = 1'b1;
            bus.wdata = 32'h1111_1111;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (mode == 2 && lat == 1) begin
                chk("wr_with_start_hi", bus.hi, prev_hi);
                chk("wr_with_start_lo", bus.lo, prev_lo);
            end
            if (mode == 1 && lat == 4) begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
                chk("wr_while_busy_hi", bus.hi, prev_hi);
                chk("wr_while_busy_lo", bus.lo, prev_lo);
            end
            if (mode == 1 && lat == 3) begin
                bus.start = 1'b1;
                bus.op    = OP_MULTU;
                bus.a     = 32'd5;
                bus.b     = 32'd7;
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = 32'hDEAD_BEEF;
            end
            if (bus.done === 1'b1) seen = 1'b1;
            else if (bus.busy === 1'b1) busy_n++;
        end
        chk("done_seen", seen, 1);
        chk("latency", lat, W + 2);
        chk("busy_cycles", busy_n, W + 1);
        chk("busy_in_done", bus.busy, 0);
    endtask

    // Reference model: expected result from plain arithmetic.
    task automatic run_model(input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input int mode);
        exp_t           e;
        logic [2*W-1:0] p;
        logic [2*W-1:0] ua;
        logic [2*W-1:0] ub;
        longint         sa;
        longint         sb;
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        p  = '0;
        case (op)
            OP_MULTU: p = ua * ub;
            OP_MULT:  p = sa * sb;
            OP_MADDU: p = {model_hi, model_lo} + ua * ub;
            OP_MADD:  p = {model_hi, model_lo} + sa * sb;
            OP_DIVU:  if (b == '0) p = {a, {W{1'b1}}};
                      else p = {a % b, a / b};
            OP_DIV:   if (b == '0) p = {a, {W{1'b1}}};
                      else p = {W'(sa % sb), W'(sa / sb)};
            default:  p = '0;
        endcase
        e.hi  = p[2*W-1:W];
        e.lo  = p[W-1:0];
        e.dbz = ((op == OP_DIVU) || (op == OP_DIV)) && (b == '0);
        run_core(op, a, b, e, mode);
    endtask

    task automatic dwrite(input logic whi, input logic wlo, input logic [W-1:0] d);
        bus.hi_we = whi;
        bus.lo_we = wlo;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        @(negedge clk);
        if (whi) model_hi = d;
        if (wlo) model_lo = d;
        $display("write hi_we=%b lo_we=%b wdata=%h", whi, wlo, d);
        chk("dwrite_hi", bus.hi, model_hi);
        chk("dwrite_lo", bus.lo, model_lo);
    endtask

    task automatic illegal(input logic [2:0] op, input logic wlo, input logic [W-1:0] d);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = W'($urandom());
        bus.b     = W'($urandom());
        bus.lo_we = wlo;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        @(negedge clk);
        if (wlo) model_lo = d;
        $display("illegal op=%b lo_we=%b", op, wlo);
        chk("illegal_busy", bus.busy, 0);
        chk("illegal_hi", bus.hi, model_hi);
        chk("illegal_lo", bus.lo, model_lo);
        repeat (3) @(negedge clk);
        chk("illegal_busy_later", bus.busy, 0);
    endtask

    task automatic reset_mid_run();
        int done_n;
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'h0001_0001;
        bus.b     = 32'h0002_0002;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        model_hi = '0;
        model_lo = '0;
        $display("reset during run");
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_done", bus.done, 0);
        chk("rst_mid_hi", bus.hi, 0);
        chk("rst_mid_lo", bus.lo, 0);
        done_n = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_n++;
        end
        chk("rst_mid_no_done", done_n, 0);
    endtask

    initial begin : stimulus
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        model_hi  = '0;
        model_lo  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_dbz", bus.dbz, 0);
        chk("reset_hi", bus.hi, 0);
        chk("reset_lo", bus.lo, 0);

        run_core(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0), 0);
        run_core(OP_MULT,  32'hFFFF_FFFD, 32'd7,         mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0), 2);
        run_core(OP_DIV,   32'hFFFF_FFF9, 32'd2,         mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0), 0);
        run_core(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0000_0000, 32'h8000_0000, 1'b0), 0);
        run_core(OP_DIVU,  32'h0000_1234, 32'd0,         mk(32'h0000_1234, 32'hFFFF_FFFF, 1'b1), 1);

        dwrite(1'b0, 1'b1, 32'h0000_CAFE);
        illegal(3'b110, 1'b1, 32'h0BAD_0001);
        illegal(3'b111, 1'b0, 32'h0);
        reset_mid_run();
        dwrite(1'b0, 1'b1, 32'd5);
`ifdef MULDIV_MADD_EN
        run_core(OP_MADDU, 32'd3, 32'd4, mk(32'd0, 32'd17, 1'b0), 0);
        run_core(OP_MADD, 32'hFFFF_FFFE, 32'd3, mk(32'd0, 32'd11, 1'b0), 0);
`else
        illegal(OP_MADDU, 1'b0, 32'h0);
        illegal(OP_MADD, 1'b0, 32'h0);
`endif
        dwrite(1'b1, 1'b1, 32'h1357_9BDF);

        for (int i = 0; i < 150; i++) begin
            int         m;
            logic [2:0] rop;
`ifdef MULDIV_MADD_EN
            rop = 3'($urandom_range(0, 5));
`else
            rop = 3'($urandom_range(0, 3));
`endif
            if ($urandom_range(0, 4) == 0) begin
                m = $urandom_range(1, 3);
                dwrite(m[1], m[0], W'($urandom()));
            end
            run_model(rop, rand_opnd(), rand_opnd(), $urandom_range(0, 2));
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit with architectural HI/LO registers, for the MIPS core.
- Replaces the single-cycle combinational multiply into HI/LO currently in the register file.
- Supports signed and unsigned MULT/DIV, plus direct HI/LO writes (MTHI/MTLO).
- Controller stalls on `busy`; MFHI/MFLO read `hi`/`lo` directly.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; product is 2*WIDTH bits.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MADDU, 101 MADD (100/101 only with the optional feature); all other codes illegal.
- a  in  WIDTH  operand A (dividend / multiplicand); sampled with start.
- b  in  WIDTH  operand B (divisor / multiplier); sampled with start.
- hi_we  in  1  write `wdata` to HI (MTHI).
- lo_we  in  1  write `wdata` to LO (MTLO).
- wdata  in  WIDTH  data for direct HI/LO write.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO now hold the result.
- dbz  out  1  divide-by-zero flag, valid while `done`=1.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state IDLE; busy=0, done=0, dbz=0, hi=0, lo=0. Reset applied mid-operation aborts it; the partial result is discarded.
- FSM states:
  - IDLE → RUN when start=1 and op is legal. Operands are latched; magnitudes are taken for signed ops (MULT/DIV/MADD).
  - RUN lasts exactly WIDTH cycles. Multiply: radix-2 shift-add, one multiplier bit per cycle. Divide: restoring, one quotient bit per cycle. An internal step counter counts 0..WIDTH-1.
  - FIX is one cycle: sign correction, then HI/LO written. → IDLE.
- Timing: start is sampled at edge k.
  - busy=1 from edge k through edge k+WIDTH+1.
  - HI/LO update at edge k+WIDTH+1.
  - done=1 and busy=0 in the cycle after that edge (WIDTH+2 cycles total).
- Result mapping:
  - Multiply: {hi,lo} = 2*WIDTH-bit product.
  - Divide: lo = quotient, hi = remainder.
- Sign rules:
  - Product sign = a[W-1]^b[W-1].
  - Quotient sign = a[W-1]^b[W-1].
  - Remainder sign = sign of dividend (truncating division).
- Signed overflow: DIV of most-negative by -1 gives lo = 1 followed by W-1 zeros (0x80000000), hi = 0; dbz = 0.
- Divide by zero (b=0, DIVU or DIV): full latency is kept; lo = all ones, hi = a (original, unsigned bit pattern); dbz = 1 with done.
- Start handling:
  - Start while busy: ignored; no queueing.
  - Illegal op: ignored; stays IDLE; busy stays 0.
- Direct writes (hi_we/lo_we):
  - Applied at the edge only in IDLE with no start accepted that cycle. Both may be set at once.
  - Start accepted in the same cycle: the writes are dropped.
  - While busy: the writes are dropped.
- Back-to-back: start may be asserted in the done cycle (state is IDLE) and is accepted.
- hi/lo hold their value at all times except on a FIX edge or a direct-write edge.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: op 100 (MADDU) and 101 (MADD) are legal.
  - Same RUN/FIX timing as multiply.
  - At FIX: {hi,lo} = {hi,lo} + product, where {hi,lo} is the value held at FIX. The sum wraps modulo 2^(2*WIDTH).
  - MADD uses the signed product.
- Undefined: ops 100/101 are illegal and ignored; no accumulator adder is instantiated.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encoding constants (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV, OP_MADDU, OP_MADD);
  - FSM state encoding (ST_IDLE, ST_RUN, ST_FIX);
  - funct codes for MFHI/MFLO/MTHI/MTLO/MULT/MULTU/DIV/DIVU, for decoder reuse.
- One sub-module, muldiv_step: combinational single iteration (shift-add or restore-subtract) selected by a mul/div flag. It is instantiated once and driven by the FSM registers.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 34 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly the cycles in between.
- MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, dbz=0.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x00001234, dbz=1 during done; second start while busy is ignored and does not change the result.
- lo_we with wdata=0xCAFE in IDLE → lo=0xCAFE next cycle; lo_we during RUN → no change; reset asserted mid-RUN → next cycle busy=0, hi=lo=0, no done pulse.
- With MULDIV_MADD_EN: lo_we wdata=5, then MADDU a=3, b=4 → hi=0, lo=17; without the macro, op=100 leaves busy=0 and hi/lo unchanged.
